// File: rtl/commit_trace_queue_if.sv
// Retire-slot inputs and commit-reporter outputs of the per-hart commit trace queue.
// The queue takes the slave side; the writeback/reporter environment takes master.
interface commit_trace_queue_if #(
    parameter int DEPTH = 8
);
    logic                     in0_valid;
    logic [31:0]              in0_pc;
    logic [31:0]              in0_inst;
    logic                     in0_is_mmio;
    logic [11:0]              in0_rcsr_id;
    logic                     in1_valid;
    logic [31:0]              in1_pc;
    logic [31:0]              in1_inst;
    logic                     in1_is_mmio;
    logic [11:0]              in1_rcsr_id;
    logic                     in_ready;
    logic                     out_valid;
    logic [31:0]              out_pc;
    logic [31:0]              out_inst;
    logic                     out_is_mmio;
    logic [11:0]              out_rcsr_id;
    logic [31:0]              out_hartid;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport master (
        output in0_valid, in0_pc, in0_inst, in0_is_mmio, in0_rcsr_id,
        output in1_valid, in1_pc, in1_inst, in1_is_mmio, in1_rcsr_id,
        input  in_ready, out_valid, out_pc, out_inst, out_is_mmio, out_rcsr_id,
        input  out_hartid, count, overflow
    );

    modport slave (
        input  in0_valid, in0_pc, in0_inst, in0_is_mmio, in0_rcsr_id,
        input  in1_valid, in1_pc, in1_inst, in1_is_mmio, in1_rcsr_id,
        output in_ready, out_valid, out_pc, out_inst, out_is_mmio, out_rcsr_id,
        output out_hartid, count, overflow
    );
endinterface

// File: rtl/commit_trace_queue.sv
// Absorbs two-wide retire bursts and replays them one per cycle, in program order,
// into the commit reporter, which has no back-pressure.
module commit_trace_queue #(
    parameter int DEPTH  = 8,
    parameter int HARTID = 0
) (
    input logic                 clock,
    input logic                 reset,
    commit_trace_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_mmio;
        logic [11:0] rcsr_id;
    } rec_t;

    rec_t          entry_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          out_valid_q, out_valid_d;
    rec_t          out_rec_q, out_rec_d;

    logic          in_ready;
    logic          deq;
    logic          wr0_en, wr1_en;
    logic [AW-1:0] wr1_idx;
    logic [1:0]    n_in;
    rec_t          in0_rec, in1_rec;

    // Admission looks only at registered occupancy, so a same-cycle dequeue never opens space.
    assign in_ready = (count_q <= CW'(DEPTH - 2));

    assign in0_rec = '{pc: bus.in0_pc, inst: bus.in0_inst,
                       is_mmio: bus.in0_is_mmio, rcsr_id: bus.in0_rcsr_id};
    assign in1_rec = '{pc: bus.in1_pc, inst: bus.in1_inst,
                       is_mmio: bus.in1_is_mmio, rcsr_id: bus.in1_rcsr_id};

    always_comb begin
        n_in        = {1'b0, bus.in0_valid} + {1'b0, bus.in1_valid};
        wr0_en      = in_ready & bus.in0_valid;
        wr1_en      = in_ready & bus.in1_valid;
        // A lone slot-1 record lands at wr_ptr so the buffer stays compacted.
        wr1_idx     = wr_ptr_q + AW'(bus.in0_valid);
        deq         = (count_q != '0);
        wr_ptr_d    = in_ready ? (wr_ptr_q + AW'(n_in)) : wr_ptr_q;
        rd_ptr_d    = rd_ptr_q + AW'(deq);
        count_d     = count_q + (in_ready ? CW'(n_in) : '0) - CW'(deq);
        overflow_d  = overflow_q | (~in_ready & (bus.in0_valid | bus.in1_valid));
        out_valid_d = deq;
        out_rec_d   = deq ? entry_mem[rd_ptr_q] : out_rec_q;
    end

    always_ff @(posedge clock) begin
        if (wr0_en) entry_mem[wr_ptr_q] <= in0_rec;
        if (wr1_en) entry_mem[wr1_idx]  <= in1_rec;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_rec_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_rec_q   <= out_rec_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_rec_q.pc;
    assign bus.out_inst    = out_rec_q.inst;
    assign bus.out_is_mmio = out_rec_q.is_mmio;
    assign bus.out_rcsr_id = out_rec_q.rcsr_id;
    assign bus.out_hartid  = 32'(HARTID);
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_commit_trace_queue.sv
// Directed bench for commit_trace_queue: reset, single/dual/slot-1 retire,
// back-pressure with wrap, overflow drop and mid-operation reset.
module tb_commit_trace_queue;
    localparam int DEPTH  = 8;
    localparam int HARTID = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    commit_trace_queue_if #(.DEPTH(DEPTH)) bus ();

    commit_trace_queue #(.DEPTH(DEPTH), .HARTID(HARTID)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in0_valid = 1'b0; bus.in0_pc = '0; bus.in0_inst = '0;
        bus.in0_is_mmio = 1'b0; bus.in0_rcsr_id = '0;
        bus.in1_valid = 1'b0; bus.in1_pc = '0; bus.in1_inst = '0;
        bus.in1_is_mmio = 1'b0; bus.in1_rcsr_id = '0;
    endtask

    task automatic drive_dual(input logic [31:0] pc0, input logic [31:0] pc1);
        bus.in0_valid = 1'b1; bus.in0_pc = pc0; bus.in0_inst = pc0 ^ 32'h00AB_0013;
        bus.in1_valid = 1'b1; bus.in1_pc = pc1; bus.in1_inst = pc1 ^ 32'h00AB_0013;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.count); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc got %h want 0", bus.out_pc); end
        vectors++; if ({bus.out_inst, bus.out_is_mmio, bus.out_rcsr_id} !== 45'h0) begin
            miscompares++; $display("FAIL reset_payload got %h/%b/%h want 0", bus.out_inst, bus.out_is_mmio, bus.out_rcsr_id); end
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        vectors++; if (bus.out_hartid !== 32'd5) begin miscompares++; $display("FAIL hartid got %0d want 5", bus.out_hartid); end
    endtask

    task automatic test_single();
        idle_inputs();
        bus.in0_valid = 1'b1; bus.in0_pc = 32'h8000_0000; bus.in0_inst = 32'h0000_0013;
        bus.in0_is_mmio = 1'b1; bus.in0_rcsr_id = 12'h0;
        tick();
        idle_inputs();
        vectors++; if (bus.count !== 4'd1 || bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_n1 got count=%0d valid=%b want 1/0", bus.count, bus.out_valid); end
        tick();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0000 || bus.out_inst !== 32'h0000_0013 || bus.out_is_mmio !== 1'b1) begin
            miscompares++; $display("FAIL single_out got v=%b pc=%h inst=%h mmio=%b want 1/80000000/00000013/1",
                                    bus.out_valid, bus.out_pc, bus.out_inst, bus.out_is_mmio); end
        vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("FAIL single_count got %0d want 0", bus.count); end
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_once got %b want 0", bus.out_valid); end
    endtask

    task automatic test_dual();
        idle_inputs();
        drive_dual(32'h100, 32'h104);
        tick();
        idle_inputs();
        vectors++; if (bus.count !== 4'd2) begin miscompares++; $display("FAIL dual_count got %0d want 2", bus.count); end
        tick();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_inst !== (32'h100 ^ 32'h00AB_0013)) begin
            miscompares++; $display("FAIL dual_first got v=%b pc=%h inst=%h want 1/100", bus.out_valid, bus.out_pc, bus.out_inst); end
        tick();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h104 || bus.out_inst !== (32'h104 ^ 32'h00AB_0013)) begin
            miscompares++; $display("FAIL dual_second got v=%b pc=%h inst=%h want 1/104", bus.out_valid, bus.out_pc, bus.out_inst); end
        tick();
        vectors++; if (bus.out_valid !== 1'b0 || bus.count !== 4'd0) begin
            miscompares++; $display("FAIL dual_end got v=%b count=%0d want 0/0", bus.out_valid, bus.count); end
    endtask

    task automatic test_slot1_only();
        idle_inputs();
        bus.in1_valid = 1'b1; bus.in1_pc = 32'h200; bus.in1_inst = 32'h3000_2573; bus.in1_rcsr_id = 12'h300;
        tick();
        idle_inputs();
        vectors++; if (bus.count !== 4'd1) begin miscompares++; $display("FAIL slot1_count got %0d want 1", bus.count); end
        tick();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_rcsr_id !== 12'h300 || bus.out_inst !== 32'h3000_2573) begin
            miscompares++; $display("FAIL slot1_out got v=%b pc=%h rcsr=%h inst=%h want 1/200/300/30002573",
                                    bus.out_valid, bus.out_pc, bus.out_rcsr_id, bus.out_inst); end
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL slot1_no_extra got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        int          tx = 0;
        int          rx = 0;
        bit          started = 1'b0;
        int          exp_cnt [7] = '{0, 2, 3, 4, 5, 6, 7};
        bit          exp_rdy [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [31:0] exp_pc;
        idle_inputs();
        for (int c = 0; c < 200 && rx < 40; c++) begin
            if (c < 7) begin
                vectors++; if (bus.count !== 4'(exp_cnt[c]) || bus.in_ready !== exp_rdy[c]) begin
                    miscompares++; $display("FAIL b2b_ramp c=%0d got count=%0d rdy=%b want %0d/%b",
                                            c, bus.count, bus.in_ready, exp_cnt[c], exp_rdy[c]); end
            end
            vectors++; if (bus.in_ready !== (bus.count <= 4'd6)) begin
                miscompares++; $display("FAIL b2b_ready c=%0d got rdy=%b count=%0d", c, bus.in_ready, bus.count); end
            if (started) begin
                vectors++; if (bus.out_valid !== 1'b1) begin
                    miscompares++; $display("FAIL b2b_gap c=%0d got out_valid=%b want 1", c, bus.out_valid); end
            end
            if (bus.out_valid === 1'b1) begin
                started = 1'b1;
                exp_pc = 32'h1000 + 32'(4 * rx);
                vectors++; if (bus.out_pc !== exp_pc) begin
                    miscompares++; $display("FAIL b2b_order rec=%0d got pc=%h want %h", rx, bus.out_pc, exp_pc); end
                rx++;
            end
            idle_inputs();
            if (bus.in_ready === 1'b1 && tx < 40) begin
                drive_dual(32'h1000 + 32'(4 * tx), 32'h1000 + 32'(4 * (tx + 1)));
                tx += 2;
            end
            tick();
        end
        idle_inputs();
        vectors++; if (rx != 40) begin miscompares++; $display("FAIL b2b_timeout got %0d records want 40", rx); end
        vectors++; if (bus.overflow !== 1'b0 || bus.count !== 4'd0) begin
            miscompares++; $display("FAIL b2b_end got ovf=%b count=%0d want 0/0", bus.overflow, bus.count); end
    endtask

    task automatic test_overflow();
        logic [31:0] sb[$];
        logic [31:0] exp_pc;
        bit          dropped = 1'b0;
        int          next_pc = 32'h3000;
        idle_inputs();
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++; $display("FAIL ovf_extra_record got pc=%h want none", bus.out_pc);
                end else begin
                    exp_pc = sb.pop_front();
                    if (bus.out_pc !== exp_pc) begin
                        miscompares++; $display("FAIL ovf_order got pc=%h want %h", bus.out_pc, exp_pc); end
                end
            end
            if (dropped) begin
                vectors++; if (bus.overflow !== 1'b1) begin
                    miscompares++; $display("FAIL ovf_sticky c=%0d got %b want 1", c, bus.overflow); end
            end
            idle_inputs();
            if (!dropped) begin
                if (bus.in_ready === 1'b1) begin
                    drive_dual(32'(next_pc), 32'(next_pc + 4));
                    sb.push_back(32'(next_pc));
                    sb.push_back(32'(next_pc + 4));
                    next_pc += 8;
                end else begin
                    vectors++; if (bus.overflow !== 1'b0) begin
                        miscompares++; $display("FAIL ovf_pre got %b want 0", bus.overflow); end
                    bus.in0_valid = 1'b1; bus.in0_pc = 32'hDEAD_0000; bus.in0_inst = 32'hDEAD_0013;
                    dropped = 1'b1;
                end
            end
            tick();
        end
        idle_inputs();
        vectors++; if (!dropped) begin miscompares++; $display("FAIL ovf_never_full got in_ready stuck at 1 want 0"); end
        vectors++; if (sb.size() != 0 || bus.count !== 4'd0) begin
            miscompares++; $display("FAIL ovf_drain got pending=%0d count=%0d want 0/0", sb.size(), bus.count); end
        vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_hold got %b want 1", bus.overflow); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            drive_dual(32'h5000 + 32'(8 * c), 32'h5004 + 32'(8 * c));
            tick();
        end
        vectors++; if (bus.count !== 4'd5 || bus.out_valid !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_pre got count=%0d v=%b want 5/1", bus.count, bus.out_valid); end
        drive_dual(32'h6000, 32'h6004);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        vectors++; if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin
            miscompares++; $display("FAIL rstmid_state got count=%0d v=%b pc=%h want 0/0/0", bus.count, bus.out_valid, bus.out_pc); end
        vectors++; if (bus.overflow !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_flags got ovf=%b rdy=%b want 0/1", bus.overflow, bus.in_ready); end
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++; if (bus.out_valid !== 1'b0) begin
                miscompares++; $display("FAIL rstmid_stale c=%0d got v=%b pc=%h want 0", c, bus.out_valid, bus.out_pc); end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_dual();
        test_slot1_only();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/commit_trace_queue.md
# commit_trace_queue

Buffers retired-instruction records from the dual-issue writeback stage and replays them one per cycle into the per-hart commit reporter (`InstFinish`). The reporter consumes `valid/pc/inst/is_mmio/rcsr_id` every cycle and has no back-pressure, so this queue absorbs two-wide retire bursts and serialises them in program order. It sits between writeback and the difftest commit interface, one instance per hart.

## Interface
- `DEPTH`, 8, number of entries; a power of two, ≥ 4.
- `HARTID`, 0, hart index driven on `out_hartid`.

- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `in0_valid` in 1: the older retire slot holds a record.
- `in0_pc` in 32: PC of slot 0.
- `in0_inst` in 32: instruction word of slot 0.
- `in0_is_mmio` in 1: slot 0 accessed MMIO.
- `in0_rcsr_id` in 12: CSR address read by slot 0.
- `in1_valid`, `in1_pc`, `in1_inst`, `in1_is_mmio`, `in1_rcsr_id` in 1/32/32/1/12: same fields for the younger slot.
- `in_ready` out 1: at least two entries are free; writeback may retire this cycle.
- `out_valid` out 1: output record is a real commit this cycle.
- `out_pc` out 32, `out_inst` out 32, `out_is_mmio` out 1, `out_rcsr_id` out 12: head record. These are registered.
- `out_hartid` out 32: constant `HARTID`.
- `count` out log2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky error flag, set when a record is dropped.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr` of log2(DEPTH) bits each, plus `count`. Both pointers wrap modulo DEPTH.
- `in_ready` = (DEPTH − `count`) ≥ 2. It is combinational from registered `count` only and does not depend on the same-cycle dequeue.
- Enqueue happens when `in_ready` = 1.
  - n_in = `in0_valid` + `in1_valid`.
  - Slot 0 is written before slot 1.
  - If only `in1_valid` is high, `in1` is written alone at `wr_ptr`; records are compacted, with no hole.
  - `wr_ptr` advances by n_in.
- Dequeue happens every cycle with `count` > 0.
  - The head entry is loaded into the output registers.
  - `out_valid` is set to 1 for the next cycle.
  - `rd_ptr` advances by 1.
- When `count` = 0, `out_valid` is loaded with 0. Payload output registers hold their previous value.
- `count_next` = `count` + (accepted n_in) − n_deq. It never exceeds DEPTH, because admission requires two free entries and dequeue only frees space.
- Any `in*_valid` high while `in_ready` = 0:
  - Those records are discarded.
  - `overflow` is set to 1.
  - No pointer moves for the input side; dequeue still proceeds.
- `overflow` stays 1 until `reset`.
- Enqueue and dequeue in the same cycle are both performed. Dequeue reads the entry at `rd_ptr` as it was before the write (registered `count` > 0 gates the read), so a record is never written and read in the same cycle.

## Timing
- Reset: on a rising edge with `reset` = 1, the block takes the state below. `reset` overrides all enqueue and dequeue activity in that cycle, including mid-burst; all queued records are lost.
  - `wr_ptr` = `rd_ptr` = `count` = 0.
  - `out_valid` = 0, `out_pc` = 0, `out_inst` = 0, `out_is_mmio` = 0, `out_rcsr_id` = 0.
  - `overflow` = 0.
  - `in_ready` = 1 in the first cycle after reset.
- Latency: a record accepted at the edge ending cycle N appears with `out_valid` = 1 during cycle N+2 if the queue was empty.
- Throughput: 1 record out per cycle. Input accepts up to 2 per cycle while `in_ready` = 1.
- With DEPTH = 8 and continuous dual retire from empty:
  - `count` sequence at the start of each cycle: 0, 2, 3, 4, 5, 6.
  - At `count` = 6, `in_ready` = 1 (2 free entries).
  - Then `count` = 7 and `in_ready` = 0 (1 free entry).
- `out_hartid` is constant and independent of `reset`.

## Test plan
- Single retire: one cycle with `in0_valid` = 1, pc = 0x80000000, inst = 0x00000013 → two cycles later `out_valid` = 1 with the same pc/inst for exactly one cycle; `count` returns to 0.
- Dual retire with ordering: one cycle with in0 pc = 0x100, in1 pc = 0x104 → `out_valid` high for 2 consecutive cycles with pc 0x100 then 0x104.
- Slot-1-only: `in1_valid` = 1 alone, pc = 0x200, `rcsr_id` = 0x300 → one output record with pc 0x200, `rcsr_id` 0x300; no empty record emitted.
- Back-pressure and wrap (DEPTH = 8):
  - Stimulus: dual retire every cycle `in_ready` = 1, with incrementing PCs, 40 records total.
  - `in_ready` drops once `count` reaches 7.
  - All 40 records exit in order with no gaps once draining starts.
  - `overflow` stays 0; pointers wrap at least 4 times.
- Overflow:
  - Stimulus: force `in0_valid` = 1 while `in_ready` = 0.
  - That record never appears on the output.
  - `overflow` = 1 from the next cycle and stays 1 until `reset`.
- Reset mid-operation:
  - Stimulus: assert `reset` for 1 cycle with `count` = 5.
  - Next cycle: `count` = 0, `out_valid` = 0, `out_pc` = 0, `overflow` = 0, `in_ready` = 1.
  - No stale record is emitted afterwards.
